q6_fb: RTL and testbench

Q6_FB -- requirements
Module: q6_fb

---
 rtl/q6_fb.sv | 62 ++++++
 tb/tb_q6_fb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/q6_fb.sv
// q6_fb: hazard-free three-input function with a registered copy and a
// monitor that flags and counts the input transitions that would glitch a
// two-term (non-consensus) implementation.
//
// Ports:
//   clk     - rising-edge clock for all registers
//   rst     - synchronous, active-high reset
//   a, b, c - function inputs, treated as synchronous to clk
//   out     - combinational out = ~a&~c | b&c | ~a&b
//   out_q   - out registered on clk (one cycle of latency)
//   hz_flag - one-cycle registered pulse after a 010<->011 transition is sampled
//   hz_cnt  - saturating count of such transitions
module q6_fb #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             out,
  output logic             out_q,
  output logic             hz_flag,
  output logic [CNT_W-1:0] hz_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [2:0] abc;
  logic [2:0] prev_abc;
  logic       hz_now;

  assign abc = {a, b, c};

  // The ~a&b consensus term keeps out high while c flips with a=0, b=1;
  // without it the ~a&~c and b&c terms hand over and can glitch low.
  assign out = (~a & ~c) | (b & c) | (~a & b);

  // Hazard-prone: both samples have a=0, b=1 and only c differs.
  always_comb begin
    hz_now = (prev_abc[2:1] == 2'b01) && (abc[2:1] == 2'b01) &&
             (prev_abc[0] != abc[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= 1'b0;
      hz_flag  <= 1'b0;
      hz_cnt   <= '0;
      // Loading the live inputs means the first post-reset sample never flags.
      prev_abc <= abc;
    end else begin
      out_q    <= out;
      hz_flag  <= hz_now;
      prev_abc <= abc;
      if (hz_now && (hz_cnt != CntMax)) begin
        hz_cnt <= hz_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_q6_fb.sv
// Directed self-checking bench for q6_fb. A second instance with CNT_W=2
// shares all inputs so counter saturation can be observed.
module tb_q6_fb;

  logic       clk;
  logic       rst;
  logic [2:0] abc;
  logic       out, out_q, hz_flag;
  logic [7:0] hz_cnt;
  logic       s_out, s_out_q, s_hz_flag;
  logic [1:0] s_hz_cnt;

  int n_pass;
  int n_total;

  q6_fb #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(abc[2]), .b(abc[1]), .c(abc[0]),
    .out(out), .out_q(out_q), .hz_flag(hz_flag), .hz_cnt(hz_cnt)
  );

  q6_fb #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .a(abc[2]), .b(abc[1]), .c(abc[0]),
    .out(s_out), .out_q(s_out_q), .hz_flag(s_hz_flag), .hz_cnt(s_hz_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] code);
    abc = code;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3'b000);
    // Still in reset-state outputs after the reset edges.
    n_total++;
    if (out_q !== 1'b0) $display("FAIL reset_out_q got=%b exp=0", out_q); else n_pass++;
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL reset_hz_flag got=%b exp=0", hz_flag); else n_pass++;
    n_total++;
    if (hz_cnt !== 8'd0) $display("FAIL reset_hz_cnt got=%0d exp=0", hz_cnt); else n_pass++;
    n_total++;
    if (out !== 1'b1) $display("FAIL reset_out_comb got=%b exp=1", out); else n_pass++;
    tick();
    n_total++;
    if (out_q !== 1'b1) $display("FAIL post_reset_out_q got=%b exp=1", out_q); else n_pass++;
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL post_reset_hz_flag got=%b exp=0", hz_flag); else n_pass++;
    n_total++;
    if (hz_cnt !== 8'd0) $display("FAIL post_reset_hz_cnt got=%0d exp=0", hz_cnt); else n_pass++;
  endtask

  task automatic test_hazard_toggle();
    logic [2:0] codes [4]  = '{3'b011, 3'b010, 3'b011, 3'b010};
    logic       first [4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] cnts  [4]  = '{8'd0, 8'd1, 8'd2, 8'd3};
    do_reset(3'b000);
    for (int i = 0; i < 4; i++) begin
      abc = codes[i];
      #1;
      n_total++;
      if (out !== 1'b1) $display("FAIL toggle_out step=%0d got=%b exp=1", i, out); else n_pass++;
      tick();
      n_total++;
      if (hz_flag !== first[i])
        $display("FAIL toggle_flag_edge1 step=%0d got=%b exp=%b", i, hz_flag, first[i]);
      else n_pass++;
      n_total++;
      if (hz_cnt !== cnts[i])
        $display("FAIL toggle_cnt step=%0d got=%0d exp=%0d", i, hz_cnt, cnts[i]);
      else n_pass++;
      tick();
      n_total++;
      if (hz_flag !== 1'b0)
        $display("FAIL toggle_flag_edge2 step=%0d got=%b exp=0", i, hz_flag);
      else n_pass++;
    end
    n_total++;
    if (hz_cnt !== 8'd3) $display("FAIL toggle_final_cnt got=%0d exp=3", hz_cnt); else n_pass++;
  endtask

  task automatic test_truth_table();
    logic [7:0] tt = 8'b1000_1101; // bit index = {a,b,c}
    logic       exp_o;
    do_reset(3'b000);
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      exp_o = tt[i];
      #1;
      n_total++;
      if (out !== exp_o) $display("FAIL tt_out abc=%03b got=%b exp=%b", abc, out, exp_o);
      else n_pass++;
      tick();
      n_total++;
      if (out_q !== exp_o) $display("FAIL tt_out_q abc=%03b got=%b exp=%b", abc, out_q, exp_o);
      else n_pass++;
    end
  endtask

  task automatic test_no_flag();
    // Multi-bit change 000->011.
    do_reset(3'b000);
    abc = 3'b011;
    tick();
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL multibit_flag got=%b exp=0", hz_flag); else n_pass++;
    // Other single-bit changes.
    do_reset(3'b001);
    abc = 3'b011;
    tick();
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL b_change_flag got=%b exp=0", hz_flag); else n_pass++;
    abc = 3'b110;
    tick();
    abc = 3'b111;
    tick();
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL a_high_flag got=%b exp=0", hz_flag); else n_pass++;
    n_total++;
    if (hz_cnt !== 8'd0) $display("FAIL no_flag_cnt got=%0d exp=0", hz_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset(3'b010);
    for (int i = 0; i < 6; i++) begin
      abc = (i % 2 == 0) ? 3'b011 : 3'b010;
      tick();
    end
    n_total++;
    if (s_hz_cnt !== 2'd3) $display("FAIL sat_small_cnt got=%0d exp=3", s_hz_cnt); else n_pass++;
    n_total++;
    if (hz_cnt !== 8'd6) $display("FAIL sat_big_cnt got=%0d exp=6", hz_cnt); else n_pass++;
    abc = 3'b011;
    tick();
    n_total++;
    if (s_hz_flag !== 1'b1) $display("FAIL sat_small_flag got=%b exp=1", s_hz_flag); else n_pass++;
    n_total++;
    if (s_hz_cnt !== 2'd3) $display("FAIL sat_hold_cnt got=%0d exp=3", s_hz_cnt); else n_pass++;
    // Constant input: no flag, no count.
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (hz_flag !== 1'b0) $display("FAIL hold_flag i=%0d got=%b exp=0", i, hz_flag); else n_pass++;
    end
    n_total++;
    if (hz_cnt !== 8'd7) $display("FAIL hold_cnt got=%0d exp=7", hz_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(3'b010);
    abc = 3'b011;
    tick();
    abc = 3'b010;
    tick();
    n_total++;
    if (hz_cnt !== 8'd2) $display("FAIL mid_pre_cnt got=%0d exp=2", hz_cnt); else n_pass++;
    // Hazard transition coincides with reset: reset wins.
    abc = 3'b011;
    rst = 1'b1;
    tick();
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL mid_rst_flag got=%b exp=0", hz_flag); else n_pass++;
    n_total++;
    if (hz_cnt !== 8'd0) $display("FAIL mid_rst_cnt got=%0d exp=0", hz_cnt); else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (hz_flag !== 1'b0) $display("FAIL first_sample_flag got=%b exp=0", hz_flag); else n_pass++;
    abc = 3'b010;
    tick();
    n_total++;
    if (hz_flag !== 1'b1) $display("FAIL resume_flag got=%b exp=1", hz_flag); else n_pass++;
    n_total++;
    if (hz_cnt !== 8'd1) $display("FAIL resume_cnt got=%0d exp=1", hz_cnt); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    abc     = 3'b000;
    test_reset();
    test_hazard_toggle();
    test_truth_table();
    test_no_flag();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
